mux_rr_arbiter: RTL and testbench
=================================

# mux_rr_arbiter

Round-robin arbiter and sequencer that shares the 8-input 1-bit serial multiplexer among eight requesters. It drives the mux select from a registered grant, so one requester at a time owns the output bit for a bounded burst of accepted beats. It also provides a valid/ready handshake toward the downstream consumer. It sits directly in front of the existing 8x1 mux datapath and is the only block allowed to drive its select.

## Interface
Parameters:
- BURST, 4, maximum accepted beats per grant; legal range 1..15.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset: one clock; reset is synchronous and active-low.
- req  input  8  request vector; bit k is requester k's request.
- i  input  8  data bits; bit k is requester k's data.
- ready  input  1  downstream accepts the current beat.
- s  output  3  mux select; registered.
- gnt  output  8  one-hot grant; registered; all zero when idle.
- o  output  1  muxed data bit, equal to i[s] in GRANT and 0 in IDLE.
- valid  output  1  beat present; combinational, equal to req[s] while in GRANT.

## Operation
- Two states: IDLE and GRANT.
- Reset values: state=IDLE, s=0, gnt=0, last=7, beat count=0. Consequently valid=0, o=0, and the first scan starts at requester 0.
- IDLE:
  - gnt=0, valid=0, o=0.
  - If req is nonzero, scan indices last+1, last+2, … (mod 8) and select the first set bit k.
  - At the next edge: s=k, gnt=1<<k, count=0, state=GRANT.
  - If req is zero, stay in IDLE; s holds its old value.
- GRANT:
  - o=i[s], valid=req[s].
  - A beat is accepted on any edge where valid && ready. Each accepted beat increments count.
  - Release at the edge where either:
    - an accepted beat has count==BURST-1, or
    - req[s]==0.
  - On release: state=IDLE, gnt=0, last=s, count=0. s holds its value.
- ready=0 in GRANT holds count and the grant indefinitely. There is no timeout.
- Requests from non-granted requesters are ignored until the next IDLE scan. Requesters are not required to hold req.
- Simultaneous release and a new request: there is always exactly one IDLE bubble cycle between grants. Re-arbitration happens in that cycle.
- A sole requester that is still requesting is regranted after the bubble; round-robin then wraps back to itself.
- rst_n low in any state, including mid-burst: all registers take their reset values at that edge. The partial burst is discarded with no notification.
- Width rules:
  - count is 4 bits; BURST ≤ 15 guarantees it never wraps.
  - Pointer arithmetic is 3-bit and wraps modulo 8.

## Timing
- Request-to-grant latency: 1 cycle. A req sampled at edge n in IDLE gives gnt/s valid after edge n (cycle n+1).
- Full burst with ready held high: BURST cycles of valid followed by 1 IDLE cycle, i.e. a period of BURST+1 cycles per grant.
- valid and o are combinational from registered s/state and from req/i. They must settle before the clk edge; there is no extra pipeline stage.
- Grant changes occur only at clk edges. s never changes while in GRANT.

## Structure
- Shared package holds:
  - N_REQ=8
  - SEL_W=3
  - CNT_W=4
  - the state enum {IDLE, GRANT}
- Sub-module: the existing 8x1 mux is instantiated as the datapath with select s. Its output is gated by state to form o.
- Round-robin scan is a combinational priority rotate in the top level; it does not need its own module.

## Test plan
- Reset: hold rst_n=0 for 2 cycles with req=8'hFF → gnt=0, s=0, valid=0, o=0 throughout.
- Single requester: req=8'h08, i=8'hC8, ready=1, BURST=4.
  - gnt=8'h08 and s=3 one cycle after req.
  - o=1 and valid=1 for 4 cycles, then 1 IDLE cycle, then regrant to 3.
- Round robin: req=8'hFF, ready=1.
  - Grant order 0,1,…,7,0.
  - Each grant lasts 4 valid cycles, with a 5-cycle period.
- Backpressure: grant 2, ready low for 3 cycles after the 2nd beat.
  - count holds; gnt=8'h04 held.
  - Burst completes after 2 more accepted beats.
- Early drop: requester 5 drops req after 2 beats while req[6] is set.
  - gnt clears at the drop edge.
  - One IDLE cycle, then gnt=8'h40.
- Reset mid-burst: assert rst_n=0 during the 3rd beat of grant 4.
  - Next edge: gnt=0, s=0, valid=0.
  - After release with req=8'h11, the first grant goes to 0.

Source files
------------

// File: rtl/mux_rr_arbiter_pkg.sv
// Shared constants and state encoding for the round-robin mux arbiter.
//   N_REQ : number of requesters / mux inputs
//   SEL_W : mux select width
//   CNT_W : beat counter width (holds up to BURST-1 for BURST <= 15)
package mux_rr_arbiter_pkg;

    localparam int unsigned N_REQ = 8;
    localparam int unsigned SEL_W = 3;
    localparam int unsigned CNT_W = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

endpackage : mux_rr_arbiter_pkg

// File: rtl/mux_rr_arbiter_mux8.sv
// Existing 8x1 one-bit serial multiplexer datapath.
// Ports:
//   i   : data bits, bit k belongs to requester k
//   s   : select
//   y_c : combinational muxed bit, i[s]
module mux_rr_arbiter_mux8
    import mux_rr_arbiter_pkg::*;
(
    input  logic [N_REQ-1:0] i,
    input  logic [SEL_W-1:0] s,
    output logic             y_c
);

    assign y_c = i[s];

endmodule : mux_rr_arbiter_mux8

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter/sequencer driving the select of the shared 8x1 mux.
// One requester at a time owns the output bit for at most BURST accepted
// beats; a single IDLE cycle always separates consecutive grants.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   req        : request vector (bit k = requester k)
//   i          : data vector (bit k = requester k)
//   ready      : downstream accepts the current beat
//   s          : registered mux select
//   gnt        : registered one-hot grant, zero when idle
//   o          : muxed data bit, i[s] in GRANT, 0 in IDLE (combinational)
//   valid      : req[s] while in GRANT (combinational)
module mux_rr_arbiter
    import mux_rr_arbiter_pkg::*;
#(
    parameter int unsigned BURST = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] i,
    input  logic             ready,
    output logic [SEL_W-1:0] s,
    output logic [N_REQ-1:0] gnt,
    output logic             o,
    output logic             valid
);

    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST - 1);

    state_e             state_q, state_d;
    logic [SEL_W-1:0]   s_q, s_d;
    logic [N_REQ-1:0]   gnt_q, gnt_d;
    logic [SEL_W-1:0]   last_q, last_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               pick_found;
    logic [SEL_W-1:0]   pick_idx;
    logic               mux_y_c;
    logic               in_grant;
    logic               beat_acc;

    // Datapath: the shared mux always follows the registered select.
    mux_rr_arbiter_mux8 u_mux (
        .i   (i),
        .s   (s_q),
        .y_c (mux_y_c)
    );

    assign in_grant = (state_q == GRANT);
    assign valid    = in_grant & req[s_q];
    assign o        = in_grant & mux_y_c;
    assign beat_acc = valid & ready;

    assign s   = s_q;
    assign gnt = gnt_q;

    // Round-robin scan: first set request starting just after the last owner.
    // Offset N_REQ wraps to last_q itself so a sole requester is regranted.
    always_comb begin
        logic [SEL_W-1:0] idx;
        pick_found = 1'b0;
        pick_idx   = '0;
        idx        = '0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            idx = last_q + SEL_W'(k);
            if (!pick_found && req[idx]) begin
                pick_found = 1'b1;
                pick_idx   = idx;
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    s_d     = pick_idx;
                    gnt_d   = N_REQ'(1) << pick_idx;
                    cnt_d   = '0;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                // Release on request drop or on the final accepted beat.
                if (!req[s_q] || (beat_acc && (cnt_q == LAST_BEAT))) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    last_d  = s_q;
                    cnt_d   = '0;
                end else if (beat_acc) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
                cnt_d   = '0;
            end
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            s_q     <= '0;
            gnt_q   <= '0;
            last_q  <= SEL_W'(N_REQ - 1);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule : mux_rr_arbiter

// File: tb/tb_mux_rr_arbiter.sv
// Directed self-checking bench for mux_rr_arbiter (BURST = 4).
module tb_mux_rr_arbiter;

    logic       clk;
    logic       rst_n;
    logic [7:0] req;
    logic [7:0] i;
    logic       ready;
    logic [2:0] s;
    logic [7:0] gnt;
    logic       o;
    logic       valid;

    int errors = 0;
    int checks = 0;

    mux_rr_arbiter #(.BURST(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .i     (i),
        .ready (ready),
        .s     (s),
        .gnt   (gnt),
        .o     (o),
        .valid (valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock edge; sample well after it.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = 8'h00;
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        logic [7:0] exp_gnt;
        int         k;

        rst_n = 1'b0;
        req   = 8'hFF;
        i     = 8'h00;
        ready = 1'b0;

        // Reset held two cycles with all requests high.
        for (int c = 0; c < 2; c++) begin
            tick();
            chk("rst_gnt",   gnt,         8'h00);
            chk("rst_s",     8'(s),       8'h00);
            chk("rst_valid", 8'(valid),   8'h00);
            chk("rst_o",     8'(o),       8'h00);
        end

        // Idle with no requests.
        rst_n = 1'b1;
        req   = 8'h00;
        tick();
        chk("idle_gnt", gnt, 8'h00);

        // Single requester 3, data bit 3 set.
        req   = 8'h08;
        i     = 8'hC8;
        ready = 1'b1;
        tick();
        chk("single_gnt", gnt,   8'h08);
        chk("single_s",   8'(s), 8'h03);
        for (int b = 0; b < 4; b++) begin
            chk("single_valid", 8'(valid), 8'h01);
            chk("single_o",     8'(o),     8'h01);
            chk("single_hold",  gnt,       8'h08);
            tick();
        end
        chk("single_bubble_gnt",   gnt,       8'h00);
        chk("single_bubble_valid", 8'(valid), 8'h00);
        chk("single_bubble_o",     8'(o),     8'h00);
        chk("single_bubble_s",     8'(s),     8'h03);
        tick();
        chk("single_regrant", gnt, 8'h08);

        // Round robin with all requesting: order 0..7,0, 5-cycle period.
        do_reset();
        chk("rr_reset_gnt", gnt, 8'h00);
        req   = 8'hFF;
        i     = 8'h55;
        ready = 1'b1;
        tick();
        for (int g = 0; g < 9; g++) begin
            k       = g % 8;
            exp_gnt = 8'(1) << k;
            chk("rr_gnt", gnt,   exp_gnt);
            chk("rr_s",   8'(s), 8'(k));
            for (int b = 0; b < 4; b++) begin
                chk("rr_valid", 8'(valid), 8'h01);
                chk("rr_o",     8'(o),     8'((k % 2) == 0 ? 1 : 0));
                tick();
            end
            chk("rr_bubble_gnt",   gnt,       8'h00);
            chk("rr_bubble_valid", 8'(valid), 8'h00);
            tick();
        end

        // Backpressure on requester 2 after the second beat.
        do_reset();
        req   = 8'h04;
        i     = 8'h04;
        ready = 1'b1;
        tick();
        chk("bp_gnt", gnt,   8'h04);
        chk("bp_s",   8'(s), 8'h02);
        tick();
        tick();
        ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            chk("bp_hold_gnt",   gnt,       8'h04);
            chk("bp_hold_valid", 8'(valid), 8'h01);
            tick();
        end
        ready = 1'b1;
        chk("bp_beat3_gnt", gnt, 8'h04);
        tick();
        chk("bp_beat4_gnt", gnt, 8'h04);
        chk("bp_beat4_o",   8'(o), 8'h01);
        tick();
        chk("bp_release_gnt", gnt, 8'h00);

        // Early drop by requester 5 while requester 6 waits.
        do_reset();
        req   = 8'h60;
        i     = 8'h00;
        ready = 1'b1;
        tick();
        chk("drop_gnt", gnt,   8'h20);
        chk("drop_s",   8'(s), 8'h05);
        tick();
        tick();
        req = 8'h40;
        #1;
        chk("drop_valid_low", 8'(valid), 8'h00);
        chk("drop_gnt_held",  gnt,       8'h20);
        tick();
        chk("drop_release_gnt", gnt, 8'h00);
        tick();
        chk("drop_next_gnt",   gnt,       8'h40);
        chk("drop_next_s",     8'(s),     8'h06);
        chk("drop_next_valid", 8'(valid), 8'h01);

        // Reset during the third beat of grant 4.
        do_reset();
        req   = 8'h10;
        ready = 1'b1;
        tick();
        chk("mid_gnt", gnt, 8'h10);
        tick();
        tick();
        chk("mid_beat3_gnt", gnt, 8'h10);
        rst_n = 1'b0;
        tick();
        chk("mid_rst_gnt",   gnt,       8'h00);
        chk("mid_rst_s",     8'(s),     8'h00);
        chk("mid_rst_valid", 8'(valid), 8'h00);
        chk("mid_rst_o",     8'(o),     8'h00);
        rst_n = 1'b1;
        req   = 8'h11;
        tick();
        chk("mid_after_gnt", gnt,   8'h01);
        chk("mid_after_s",   8'(s), 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_mux_rr_arbiter
